// File: rtl/decode_queue.sv
// decode_queue: RV32I decode-on-entry FIFO between fetch and execute.
// Optional DECODE_QUEUE_STATS_EN adds stat_accepted / stat_illegal counters.
module decode_queue #(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [4:0]      rs1_address,
   output logic [4:0]      rs2_address,
   output logic [4:0]      rd_address,
   output logic [XLEN-1:0] imm,
   output logic [3:0]      alu_rd_operator,
   output logic [1:0]      alu_rd_operand1_src,
   output logic [2:0]      alu_rd_operand2_src,
   output logic [1:0]      alu_pc_operand1_src,
   output logic [1:0]      next_pc_src,
   output logic            reg_write_data_src,
   output logic            reg_wren,
   output logic            ram_wren,
   output logic            illegal
`ifdef DECODE_QUEUE_STATS_EN
   ,
   output logic [31:0]     stat_accepted,
   output logic [31:0]     stat_illegal
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [3:0] ALU_OPERATOR_ADD  = 4'd0;
   localparam logic [3:0] ALU_OPERATOR_SUB  = 4'd1;
   localparam logic [3:0] ALU_OPERATOR_SLL  = 4'd2;
   localparam logic [3:0] ALU_OPERATOR_SLT  = 4'd3;
   localparam logic [3:0] ALU_OPERATOR_SLTU = 4'd4;
   localparam logic [3:0] ALU_OPERATOR_XOR  = 4'd5;
   localparam logic [3:0] ALU_OPERATOR_SRL  = 4'd6;
   localparam logic [3:0] ALU_OPERATOR_SRA  = 4'd7;
   localparam logic [3:0] ALU_OPERATOR_OR   = 4'd8;
   localparam logic [3:0] ALU_OPERATOR_AND  = 4'd9;

   localparam logic [1:0] ALU_RD_OPERAND1_SRC_RS1 = 2'd0;
   localparam logic [1:0] ALU_RD_OPERAND1_SRC_PC  = 2'd1;
   localparam logic [1:0] ALU_RD_OPERAND1_SRC_IMM = 2'd2;

   localparam logic [2:0] ALU_RD_OPERAND2_SRC_RS2    = 3'd0;
   localparam logic [2:0] ALU_RD_OPERAND2_SRC_IMM    = 3'd1;
   localparam logic [2:0] ALU_RD_OPERAND2_SRC_FOUR   = 3'd2;
   localparam logic [2:0] ALU_RD_OPERAND2_SRC_TWELVE = 3'd3;

   localparam logic [1:0] ALU_PC_OPERAND1_SRC_PC  = 2'd0;
   localparam logic [1:0] ALU_PC_OPERAND1_SRC_RS1 = 2'd1;

   localparam logic [1:0] NEXT_PC_SRC_ALWAYS_NOT_BRANCH = 2'd0;
   localparam logic [1:0] NEXT_PC_SRC_ALWAYS_BRANCH = 2'd1;
   localparam logic [1:0] NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_ZERO = 2'd2;
   localparam logic [1:0] NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_NONZERO = 2'd3;

   localparam logic REG_WRITE_DATA_SRC_ALU = 1'b0;
   localparam logic REG_WRITE_DATA_SRC_RAM = 1'b1;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [3:0]      op;
      logic [1:0]      op1;
      logic [2:0]      op2;
      logic [1:0]      pco;
      logic [1:0]      npc;
      logic            wds;
      logic            regw;
      logic            ramw;
      logic            ill;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          dec;
   entry_t          head;
   logic [AW-1:0]   wptr;
   logic [AW-1:0]   rptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;
   logic            legal;

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc = in_instr[6:0];
   assign f3  = in_instr[14:12];
   assign f7  = in_instr[31:25];

   function automatic logic [3:0] alu_op(input logic [2:0] fn, input logic alt);
      case (fn)
         3'b000:  alu_op = alt ? ALU_OPERATOR_SUB : ALU_OPERATOR_ADD;
         3'b001:  alu_op = ALU_OPERATOR_SLL;
         3'b010:  alu_op = ALU_OPERATOR_SLT;
         3'b011:  alu_op = ALU_OPERATOR_SLTU;
         3'b100:  alu_op = ALU_OPERATOR_XOR;
         3'b101:  alu_op = alt ? ALU_OPERATOR_SRA : ALU_OPERATOR_SRL;
         3'b110:  alu_op = ALU_OPERATOR_OR;
         default: alu_op = ALU_OPERATOR_AND;
      endcase
   endfunction

   always_comb begin
      dec       = '0;
      dec.pc    = in_pc;
      dec.rs1   = in_instr[19:15];
      dec.rs2   = in_instr[24:20];
      dec.rd    = in_instr[11:7];
      dec.npc   = NEXT_PC_SRC_ALWAYS_NOT_BRANCH;
      legal     = 1'b1;
      case (opc)
         OPC_LUI: begin
            // rd = sext(instr[31:12]) << 12 computed by the ALU
            dec.imm  = {{(XLEN-20){in_instr[31]}}, in_instr[31:12]};
            dec.op   = ALU_OPERATOR_SLL;
            dec.op1  = ALU_RD_OPERAND1_SRC_IMM;
            dec.op2  = ALU_RD_OPERAND2_SRC_TWELVE;
            dec.regw = 1'b1;
         end
         OPC_AUIPC: begin
            dec.imm  = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
            dec.op1  = ALU_RD_OPERAND1_SRC_PC;
            dec.op2  = ALU_RD_OPERAND2_SRC_IMM;
            dec.regw = 1'b1;
         end
         OPC_JAL: begin
            dec.imm  = {{(XLEN-20){in_instr[31]}}, in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
            dec.op1  = ALU_RD_OPERAND1_SRC_PC;
            dec.op2  = ALU_RD_OPERAND2_SRC_FOUR;
            dec.npc  = NEXT_PC_SRC_ALWAYS_BRANCH;
            dec.regw = 1'b1;
         end
         OPC_JALR: begin
            dec.imm  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            dec.op1  = ALU_RD_OPERAND1_SRC_PC;
            dec.op2  = ALU_RD_OPERAND2_SRC_FOUR;
            dec.pco  = ALU_PC_OPERAND1_SRC_RS1;
            dec.npc  = NEXT_PC_SRC_ALWAYS_BRANCH;
            dec.regw = 1'b1;
            legal    = (f3 == 3'b000);
         end
         OPC_BRANCH: begin
            dec.imm = {{(XLEN-12){in_instr[31]}}, in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
            dec.op  = f3[1] ? ALU_OPERATOR_SLTU :
                      f3[2] ? ALU_OPERATOR_SLT : ALU_OPERATOR_SUB;
            // odd funct3 inverts the sense: BNE/BGE/BGEU
            dec.npc = (f3[0] ^ f3[2]) ?
                      NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_NONZERO :
                      NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_ZERO;
            legal   = (f3 != 3'b010) && (f3 != 3'b011);
         end
         OPC_LOAD: begin
            dec.imm  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            dec.op2  = ALU_RD_OPERAND2_SRC_IMM;
            dec.wds  = REG_WRITE_DATA_SRC_RAM;
            dec.regw = 1'b1;
         end
         OPC_STORE: begin
            dec.imm  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            dec.op2  = ALU_RD_OPERAND2_SRC_IMM;
            dec.ramw = 1'b1;
         end
         OPC_OPIMM: begin
            dec.imm  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            dec.op   = alu_op(f3, (f3 == 3'b101) && f7[5]);
            dec.op2  = ALU_RD_OPERAND2_SRC_IMM;
            dec.wds  = REG_WRITE_DATA_SRC_ALU;
            dec.regw = 1'b1;
            if (f3 == 3'b001)
               legal = (f7 == 7'h00);
            else if (f3 == 3'b101)
               legal = (f7 == 7'h00) || (f7 == 7'h20);
         end
         OPC_OP: begin
            dec.op   = alu_op(f3, f7[5]);
            dec.op2  = ALU_RD_OPERAND2_SRC_RS2;
            dec.regw = 1'b1;
            legal    = (f7 == 7'h00) ||
                       ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec     = '0;
         dec.pc  = in_pc;
         dec.ill = 1'b1;
      end
      if (dec.rd == 5'd0)
         dec.regw = 1'b0;
   end

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= dec;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef DECODE_QUEUE_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_accepted <= '0;
         stat_illegal  <= '0;
      end else if (push) begin
         stat_accepted <= stat_accepted + 32'd1;
         if (dec.ill)
            stat_illegal <= stat_illegal + 32'd1;
      end
   end
`endif

   assign head = out_valid ? mem[rptr] : '0;

   assign out_pc              = head.pc;
   assign rs1_address         = head.rs1;
   assign rs2_address         = head.rs2;
   assign rd_address          = head.rd;
   assign imm                 = head.imm;
   assign alu_rd_operator     = head.op;
   assign alu_rd_operand1_src = head.op1;
   assign alu_rd_operand2_src = head.op2;
   assign alu_pc_operand1_src = head.pco;
   assign next_pc_src         = head.npc;
   assign reg_write_data_src  = head.wds;
   assign reg_wren            = head.regw;
   assign ram_wren            = head.ramw;
   assign illegal             = head.ill;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue.
// Stats ports checked only when DECODE_QUEUE_STATS_EN is defined.
module tb_decode_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [4:0]  rs1_address;
   logic [4:0]  rs2_address;
   logic [4:0]  rd_address;
   logic [31:0] imm;
   logic [3:0]  alu_rd_operator;
   logic [1:0]  alu_rd_operand1_src;
   logic [2:0]  alu_rd_operand2_src;
   logic [1:0]  alu_pc_operand1_src;
   logic [1:0]  next_pc_src;
   logic        reg_write_data_src;
   logic        reg_wren;
   logic        ram_wren;
   logic        illegal;
`ifdef DECODE_QUEUE_STATS_EN
   logic [31:0] stat_accepted;
   logic [31:0] stat_illegal;
`endif

   int checks = 0;
   int errors = 0;

   decode_queue #(.XLEN(32), .PC_W(32), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .rs1_address(rs1_address), .rs2_address(rs2_address),
      .rd_address(rd_address), .imm(imm),
      .alu_rd_operator(alu_rd_operator),
      .alu_rd_operand1_src(alu_rd_operand1_src),
      .alu_rd_operand2_src(alu_rd_operand2_src),
      .alu_pc_operand1_src(alu_pc_operand1_src),
      .next_pc_src(next_pc_src),
      .reg_write_data_src(reg_write_data_src),
      .reg_wren(reg_wren), .ram_wren(ram_wren), .illegal(illegal)
`ifdef DECODE_QUEUE_STATS_EN
      , .stat_accepted(stat_accepted), .stat_illegal(stat_illegal)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop_one;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
      checks++; if (imm !== 32'h0 || reg_wren !== 1'b0) begin errors++; $display("FAIL reset_zero imm=%0h wren=%0h exp=0", imm, reg_wren); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_addi;
      push_one(32'hFFF00093, 32'h100);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got=%0h exp=1", out_valid); end
      checks++; if (rd_address !== 5'd1 || rs1_address !== 5'd0) begin errors++; $display("FAIL addi_regs rd=%0d rs1=%0d exp=1,0", rd_address, rs1_address); end
      checks++; if (imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got=%0h exp=ffffffff", imm); end
      checks++; if (alu_rd_operator !== 4'd0 || alu_rd_operand2_src !== 3'd1) begin errors++; $display("FAIL addi_alu op=%0d src2=%0d exp=0,1", alu_rd_operator, alu_rd_operand2_src); end
      checks++; if (reg_wren !== 1'b1 || illegal !== 1'b0 || out_pc !== 32'h100) begin errors++; $display("FAIL addi_ctl wren=%0h ill=%0h pc=%0h exp=1,0,100", reg_wren, illegal, out_pc); end
      pop_one();
      checks++; if (out_valid !== 1'b0 || imm !== 32'h0) begin errors++; $display("FAIL addi_drain valid=%0h imm=%0h exp=0,0", out_valid, imm); end
   endtask

   task automatic test_full;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         push_one((32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13, 32'h200 + 32'(4 * i));
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%0h exp=0", in_ready); end
      in_valid = 1'b1;
      in_instr = 32'h00500293;
      in_pc    = 32'h210;
      tick();
      checks++; if (in_ready !== 1'b0 || out_pc !== 32'h200) begin errors++; $display("FAIL full_hold rdy=%0h pc=%0h exp=0,200", in_ready, out_pc); end
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_pc !== 32'h204) begin errors++; $display("FAIL full_pop rdy=%0h pc=%0h exp=1,204", in_ready, out_pc); end
      out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         checks++;
         if (out_pc !== 32'h200 + 32'(4 * i) || rd_address !== 5'(i + 1)) begin
            errors++;
            $display("FAIL full_order%0d pc=%0h rd=%0d exp=%0h,%0d", i, out_pc, rd_address, 32'h200 + 32'(4 * i), i + 1);
         end
         tick();
      end
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_fifth_dropped got=%0h exp=0", out_valid); end
   endtask

   task automatic test_back_to_back;
      push_one(32'h00100093, 32'h300);
      push_one(32'h00100093, 32'h304);
      for (int k = 0; k < 10; k++) begin
         in_valid  = 1'b1;
         in_instr  = 32'h00100093;
         in_pc     = 32'h308 + 32'(4 * k);
         out_ready = 1'b1;
         checks++;
         if (out_pc !== 32'h300 + 32'(4 * k) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d pc=%0h rdy=%0h exp=%0h,1", k, out_pc, in_ready, 32'h300 + 32'(4 * k));
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++; if (out_pc !== 32'h328) begin errors++; $display("FAIL b2b_tail0 got=%0h exp=328", out_pc); end
      pop_one();
      checks++; if (out_pc !== 32'h32c) begin errors++; $display("FAIL b2b_tail1 got=%0h exp=32c", out_pc); end
      pop_one();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got=%0h exp=0", out_valid); end
   endtask

   task automatic test_illegal;
      logic [31:0] bad [3];
`ifdef DECODE_QUEUE_STATS_EN
      logic [31:0] acc0;
      logic [31:0] ill0;
      acc0 = stat_accepted;
      ill0 = stat_illegal;
`endif
      push_one(32'h00000000, 32'h400);
      push_one(32'h00208033, 32'h404);
`ifdef DECODE_QUEUE_STATS_EN
      checks++; if (stat_accepted - acc0 !== 32'd2 || stat_illegal - ill0 !== 32'd1) begin errors++; $display("FAIL stats acc=%0d ill=%0d exp=2,1", stat_accepted - acc0, stat_illegal - ill0); end
`endif
      checks++; if (illegal !== 1'b1 || reg_wren !== 1'b0 || next_pc_src !== 2'd0) begin errors++; $display("FAIL ill_zero ill=%0h wren=%0h npc=%0h exp=1,0,0", illegal, reg_wren, next_pc_src); end
      pop_one();
      checks++; if (illegal !== 1'b0 || reg_wren !== 1'b0 || rd_address !== 5'd0) begin errors++; $display("FAIL add_x0 ill=%0h wren=%0h rd=%0d exp=0,0,0", illegal, reg_wren, rd_address); end
      checks++; if (rs1_address !== 5'd1 || rs2_address !== 5'd2 || alu_rd_operator !== 4'd0) begin errors++; $display("FAIL add_x0_fields rs1=%0d rs2=%0d op=%0d exp=1,2,0", rs1_address, rs2_address, alu_rd_operator); end
      pop_one();
      bad[0] = 32'h40209033;
      bad[1] = 32'h00002063;
      bad[2] = 32'h000010E7;
      for (int i = 0; i < 3; i++) begin
         push_one(bad[i], 32'h500);
         checks++;
         if (illegal !== 1'b1 || reg_wren !== 1'b0 || rs1_address !== 5'd0) begin
            errors++;
            $display("FAIL ill_vec%0d ill=%0h wren=%0h rs1=%0d exp=1,0,0", i, illegal, reg_wren, rs1_address);
         end
         pop_one();
      end
   endtask

   task automatic test_imm_forms;
      push_one(32'hFE000EE3, 32'h600);
      checks++; if (imm !== 32'hFFFFFFFC || alu_rd_operator !== 4'd1) begin errors++; $display("FAIL beq imm=%0h op=%0d exp=fffffffc,1", imm, alu_rd_operator); end
      checks++; if (next_pc_src !== 2'd2 || reg_wren !== 1'b0) begin errors++; $display("FAIL beq_ctl npc=%0d wren=%0h exp=2,0", next_pc_src, reg_wren); end
      pop_one();
      push_one(32'h123450B7, 32'h604);
      checks++; if (imm !== 32'h00012345 || alu_rd_operator !== 4'd2) begin errors++; $display("FAIL lui imm=%0h op=%0d exp=12345,2", imm, alu_rd_operator); end
      checks++; if (alu_rd_operand1_src !== 2'd2 || alu_rd_operand2_src !== 3'd3 || reg_wren !== 1'b1) begin errors++; $display("FAIL lui_src s1=%0d s2=%0d wren=%0h exp=2,3,1", alu_rd_operand1_src, alu_rd_operand2_src, reg_wren); end
      pop_one();
      push_one(32'hFE20AC23, 32'h608);
      checks++; if (imm !== 32'hFFFFFFF8 || ram_wren !== 1'b1 || reg_wren !== 1'b0) begin errors++; $display("FAIL sw imm=%0h ram=%0h reg=%0h exp=fffffff8,1,0", imm, ram_wren, reg_wren); end
      pop_one();
      push_one(32'h008000EF, 32'h60c);
      checks++; if (imm !== 32'h8 || next_pc_src !== 2'd1 || alu_rd_operand2_src !== 3'd2) begin errors++; $display("FAIL jal imm=%0h npc=%0d s2=%0d exp=8,1,2", imm, next_pc_src, alu_rd_operand2_src); end
      pop_one();
   endtask

   task automatic test_flush;
      for (int i = 0; i < 3; i++)
         push_one(32'h00100093, 32'h700 + 32'(4 * i));
      in_valid = 1'b1;
      in_instr = 32'h00100093;
      in_pc    = 32'h70c;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush valid=%0h rdy=%0h exp=0,1", out_valid, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got=%0h exp=0", out_valid); end
      for (int i = 0; i < 3; i++)
         push_one(32'h00100093, 32'h800 + 32'(4 * i));
      in_valid = 1'b1;
      rst_n    = 1'b0;
      tick();
      rst_n    = 1'b1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid valid=%0h rdy=%0h exp=0,1", out_valid, in_ready); end
      push_one(32'h00100093, 32'h900);
      checks++; if (out_pc !== 32'h900) begin errors++; $display("FAIL rstmid_fresh got=%0h exp=900", out_pc); end
      pop_one();
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      test_reset();
      test_addi();
      test_full();
      test_back_to_back();
      test_illegal();
      test_imm_forms();
      test_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, buffered successor to the combinational RV32I decoder.
- Accepts fetched instruction+PC over a valid/ready handshake, decodes on entry and stores the decoded control bundle in a DEPTH-entry FIFO.
- Presents the bundle to the execute stage over a second valid/ready handshake.
- Adds sign-extended immediates, illegal-instruction flagging, x0 write suppression and pipeline flush.

Parameters:
XLEN, 32, datapath width; imm sign-extended to XLEN; legal values 32 or 64
PC_W, 32, PC width carried alongside each entry
DEPTH, 4, FIFO entries; power of two, >=2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  discard all queued entries this cycle
in_valid  in  1  fetch offers instruction
in_ready  out  1  queue can accept
in_instr  in  32  instruction word
in_pc  in  PC_W  instruction address
out_valid  out  1  head entry valid
out_ready  in  1  execute consumes head
out_pc  out  PC_W  PC of head entry
rs1_address  out  5  head rs1 field
rs2_address  out  5  head rs2 field
rd_address  out  5  head rd field
imm  out  XLEN  sign-extended immediate
alu_rd_operator  out  4  ALU operator code (define.v ALU_OPERATOR_*)
alu_rd_operand1_src  out  2  define.v ALU_RD_OPERAND1_SRC_*
alu_rd_operand2_src  out  3  define.v ALU_RD_OPERAND2_SRC_*
alu_pc_operand1_src  out  2  define.v ALU_PC_OPERAND1_SRC_*
next_pc_src  out  2  define.v NEXT_PC_SRC_*
reg_write_data_src  out  1  ALU or RAM writeback
reg_wren  out  1  register write enable
ram_wren  out  1  RAM write enable
illegal  out  1  head instruction not decodable

Behaviour:
- Reset (rst_n=0 at posedge): count=0, read/write pointers=0, out_valid=0, in_ready=1. All bundle outputs are 0 while out_valid=0. Reset mid-transfer drops all entries; no partial state survives.
- Push = in_valid&in_ready. Pop = out_valid&out_ready. Both take effect at the posedge.
- in_ready = (count != DEPTH), driven from registered count only; no combinational path from out_ready. When full, a simultaneous pop does not admit a push in the same cycle.
- Latency: an instruction accepted at edge N is visible on out_* after edge N (one cycle) when the queue was empty. Otherwise it appears in FIFO order.
- Push and pop in the same cycle: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Empty: out_valid=0 and outputs are zeroed. Pop is impossible.
- flush has priority over push and pop. Next cycle: count=0, pointers reset, out_valid=0. An in_valid beat in the flush cycle is dropped.
- Decode happens at push and uses the field mapping and control codes of the RV32I decoder, with these corrections:
  - imm_i = sext(instr[31:20]).
  - imm_s = sext({instr[31:25], instr[11:7]}).
  - imm_b = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - imm_u = sext({instr[31:12], 12'b0}).
  - imm_j = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - LUI: operand1 src IMM, operand2 src 12, operator SLL, with imm = sext(instr[31:12]). Same ALU contract as before.
  - Every output has a defined value for every opcode; no latches.
- illegal=1 when any of the following holds:
  - opcode is not one of the nine RV32I base opcodes;
  - OP funct7 is not ADD/SUB (funct3=000) or SRL/SRA (funct3=101);
  - OP funct7 is nonzero for any other funct3;
  - SLLI/SRLI/SRAI funct7 is invalid;
  - branch funct3 is 010 or 011;
  - JALR funct3 is nonzero.
- Illegal entries still queue in order, with reg_wren=0, ram_wren=0, next_pc_src=NEXT_PC_SRC_ALWAYS_NOT_BRANCH and other fields 0.
- rd_address=0 forces reg_wren=0.

Optional Feature:
- Macro: DECODE_QUEUE_STATS_EN.
- When defined, adds outputs stat_accepted (32 bits), counting pushes, and stat_illegal (32 bits), counting pushes decoded as illegal.
- Both counters wrap on overflow, clear on reset, and are not cleared by flush.
- When undefined, these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Push 0xFFF00093 (ADDI x1,x0,-1) into empty queue, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, ADD, operand2 src IMM, reg_wren=1.
- out_ready=0, push 4 beats -> in_ready=0 after the 4th edge; a 5th beat is held. Pop 1 -> in_ready=1 the following cycle. Pops return in push order.
- count=2, push and pop simultaneously for 10 cycles -> count stays 2, order preserved across pointer wrap.
- Push 0x00000000, then 0x00208033 (ADD x0,x1,x2) -> first entry illegal=1, reg_wren=0. Second entry illegal=0, reg_wren=0. stat_illegal=1, stat_accepted=2 when DECODE_QUEUE_STATS_EN.
- Push 0xFE000EE3 (BEQ x0,x0,-4) -> imm=0xFFFFFFFC, SUB, NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_ZERO. Push 0x123450B7 (LUI) -> imm=0x00012345.
- Queue holds 3 entries: assert flush together with in_valid -> next cycle out_valid=0, in_ready=1. The same sequence with rst_n=0 instead gives the same result.
